// File: rtl/sparc_pkg.sv
// sparc_pkg: opcode fields shared by the ALU and memory stage,
// plus the memory-stage state and request-context types.
package sparc_pkg;

    localparam logic [1:0] OP_BR   = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_LD   = 6'b000000;
    localparam logic [5:0] OP3_LDUB = 6'b000001;
    localparam logic [5:0] OP3_LDUH = 6'b000010;
    localparam logic [5:0] OP3_LDSB = 6'b001001;
    localparam logic [5:0] OP3_LDSH = 6'b001010;
    localparam logic [5:0] OP3_ST   = 6'b000100;
    localparam logic [5:0] OP3_STB  = 6'b000101;
    localparam logic [5:0] OP3_STH  = 6'b000110;

    typedef enum logic {IDLE, REQ} mem_state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [5:0] op3;
        logic [1:0] off;
        logic       store;
    } mem_ctx_t;

    function automatic logic is_mem_op(
        input logic [1:0] op,
        input logic [5:0] op3
    );
        return (op == OP_MEM) && (op3 inside {
            OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDSB,
            OP3_LDSH, OP3_ST, OP3_STB, OP3_STH});
    endfunction

    function automatic logic is_store_op(input logic [5:0] op3);
        return op3 inside {OP3_ST, OP3_STB, OP3_STH};
    endfunction

    function automatic logic is_word_op(input logic [5:0] op3);
        return op3 inside {OP3_LD, OP3_ST};
    endfunction

    function automatic logic is_half_op(input logic [5:0] op3);
        return op3 inside {OP3_LDUH, OP3_LDSH, OP3_STH};
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian store lane replication / byte enables
// and load lane extraction with sign or zero extension.
module mem_lane_align
    import sparc_pkg::*;
(
    input  logic [5:0]  s_op3,
    input  logic [1:0]  s_off,
    input  logic [31:0] s_data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    input  logic [5:0]  l_op3,
    input  logic [1:0]  l_off,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [7:0]  l_byte;
    logic [15:0] l_half;
    logic        l_sgn;

    // store: replicate the datum across lanes, enable the addressed lanes
    always_comb begin
        wdata = s_data;
        be    = 4'b1111;
        unique case (1'b1)
            is_word_op(s_op3): begin
                wdata = s_data;
                be    = 4'b1111;
            end
            is_half_op(s_op3): begin
                wdata = {2{s_data[15:0]}};
                be    = s_off[1] ? 4'b0011 : 4'b1100;
            end
            default: begin
                wdata = {4{s_data[7:0]}};
                be    = 4'b1000 >> s_off;
            end
        endcase
    end

    // load: offset 0 is the most significant lane
    always_comb begin
        l_byte = rdata[31:24];
        unique case (l_off)
            2'd0: l_byte = rdata[31:24];
            2'd1: l_byte = rdata[23:16];
            2'd2: l_byte = rdata[15:8];
            2'd3: l_byte = rdata[7:0];
        endcase
        l_half = l_off[1] ? rdata[15:0] : rdata[31:16];
        l_sgn  = l_op3 inside {OP3_LDSB, OP3_LDSH};
        unique case (1'b1)
            is_word_op(l_op3):
                ldata = rdata;
            is_half_op(l_op3):
                ldata = {{16{l_sgn & l_half[15]}}, l_half};
            default:
                ldata = {{24{l_sgn & l_byte[7]}}, l_byte};
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; drives the req/ack data bus and
// emits one registered writeback record per instruction.
module mem_stage
    import sparc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_valid_in,
    output logic        MEM_ready_out,
    input  logic [1:0]  MEM_op_in,
    input  logic [2:0]  MEM_op2_in,
    input  logic [5:0]  MEM_op3_in,
    input  logic [4:0]  MEM_rd_in,
    input  logic [31:0] MEM_res_in,
    input  logic [31:0] MEM_store_in,
    input  logic [31:0] MEM_PC_in,
    output logic        MEM_req_out,
    output logic        MEM_we_out,
    output logic [31:0] MEM_addr_out,
    output logic [31:0] MEM_wdata_out,
    output logic [3:0]  MEM_be_out,
    input  logic [31:0] MEM_rdata_in,
    input  logic        MEM_ack_in,
    output logic        WB_valid_out,
    output logic        WB_we_out,
    output logic [4:0]  WB_rd_out,
    output logic [31:0] WB_data_out,
    output logic        MEM_align_trap_out,
    output logic        MEM_bus_err_out
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    mem_state_t  state;
    mem_ctx_t    ctx;
    logic [7:0]  cnt;
    logic        accept;
    logic        mem_op;
    logic        st_op;
    logic        misalign;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] lane_ldata;
    logic        nm_we;
    logic [4:0]  nm_rd;
    logic [31:0] nm_data;

    assign MEM_ready_out = rst_n & (state == IDLE);
    assign accept = MEM_valid_in & MEM_ready_out;
    assign mem_op = is_mem_op(MEM_op_in, MEM_op3_in);
    assign st_op  = is_store_op(MEM_op3_in);

    mem_lane_align u_align (
        .s_op3  (MEM_op3_in),
        .s_off  (MEM_res_in[1:0]),
        .s_data (MEM_store_in),
        .wdata  (lane_wdata),
        .be     (lane_be),
        .l_op3  (ctx.op3),
        .l_off  (ctx.off),
        .rdata  (MEM_rdata_in),
        .ldata  (lane_ldata)
    );

    // word needs offset 0, half needs even offset, byte always fits
    always_comb begin
        misalign = 1'b0;
        unique case (1'b1)
            is_word_op(MEM_op3_in):
                misalign = |MEM_res_in[1:0];
            is_half_op(MEM_op3_in):
                misalign = MEM_res_in[0];
            default:
                misalign = 1'b0;
        endcase
        misalign = misalign & mem_op;
    end

    // writeback record for instructions that never touch the bus
    always_comb begin
        nm_we   = 1'b0;
        nm_rd   = MEM_rd_in;
        nm_data = '0;
        unique case (1'b1)
            (MEM_op_in == OP_ALU),
            (MEM_op_in == OP_BR && MEM_op2_in == OP2_SETHI): begin
                nm_data = MEM_res_in;
                nm_we   = (MEM_rd_in != 5'd0);
            end
            (MEM_op_in == OP_CALL): begin
                nm_data = MEM_PC_in;
                nm_rd   = 5'd15;
                nm_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // FSM, timeout counter, bus and writeback registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ctx                <= '0;
            cnt                <= '0;
            MEM_req_out        <= 1'b0;
            MEM_we_out         <= 1'b0;
            MEM_addr_out       <= '0;
            MEM_wdata_out      <= '0;
            MEM_be_out         <= '0;
            WB_valid_out       <= 1'b0;
            WB_we_out          <= 1'b0;
            WB_rd_out          <= '0;
            WB_data_out        <= '0;
            MEM_align_trap_out <= 1'b0;
            MEM_bus_err_out    <= 1'b0;
        end else begin
            WB_valid_out       <= 1'b0;
            WB_we_out          <= 1'b0;
            MEM_align_trap_out <= 1'b0;
            MEM_bus_err_out    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && mem_op && !misalign) begin
                        state         <= REQ;
                        cnt           <= 8'd1;
                        MEM_req_out   <= 1'b1;
                        MEM_we_out    <= st_op;
                        MEM_addr_out  <= {MEM_res_in[31:2], 2'b00};
                        MEM_be_out    <= lane_be;
                        MEM_wdata_out <= st_op ? lane_wdata : '0;
                        ctx.rd        <= MEM_rd_in;
                        ctx.op3       <= MEM_op3_in;
                        ctx.off       <= MEM_res_in[1:0];
                        ctx.store     <= st_op;
                    end else if (accept) begin
                        WB_valid_out       <= 1'b1;
                        WB_we_out          <= nm_we & ~misalign;
                        WB_rd_out          <= nm_rd;
                        WB_data_out        <= nm_data;
                        MEM_align_trap_out <= misalign;
                    end
                end
                REQ: begin
                    if (MEM_ack_in || cnt == WAIT_LIM) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        MEM_req_out  <= 1'b0;
                        MEM_we_out   <= 1'b0;
                        MEM_be_out   <= '0;
                        WB_valid_out <= 1'b1;
                        WB_rd_out    <= ctx.rd;
                        WB_data_out  <= '0;
                        if (MEM_ack_in) begin
                            if (!ctx.store) begin
                                WB_we_out   <= (ctx.rd != 5'd0);
                                WB_data_out <= lane_ldata;
                            end
                        end else begin
                            MEM_bus_err_out <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
